// File: rtl/func_drain_pkg.sv
// Shared types and constants for the func_stream_drain output stage.
//   drain_state_t : FSM state encoding (IDLE -> RUN -> TAIL -> IDLE)
//   drain_beat_t  : one buffered beat, result data plus its tlast flag
//   sat_inc       : 32-bit saturating increment for the statistics counters
package func_drain_pkg;

  localparam int DRAIN_DATA_W = 128;
  localparam int SKID_DEPTH   = 2;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RUN  = 2'd1,
    ST_TAIL = 2'd2
  } drain_state_t;

  typedef struct packed {
    logic                    last;
    logic [DRAIN_DATA_W-1:0] data;
  } drain_beat_t;

  function automatic logic [31:0] sat_inc(input logic [31:0] v);
    return (v == 32'hFFFF_FFFF) ? v : v + 32'd1;
  endfunction

endpackage

// File: rtl/func_skid_buf.sv
// Two-entry (SKID_DEPTH) valid/ready register slice carrying drain_beat_t.
// The head entry drives the output directly, so o_beat is registered and
// a beat pushed in cycle t is visible at the output in cycle t+1. The spare
// entry absorbs the one beat that can arrive while the sink stalls, which
// keeps full throughput without a combinational ready path.
// Ports:
//   aclk, areset : clock, synchronous active-high reset
//   i_valid      : push request (caller qualifies it with !o_full)
//   i_beat       : beat to push
//   o_beat       : head beat (valid when !o_empty)
//   i_ready      : sink accepts the head beat this cycle
//   o_full       : both entries occupied, no push allowed
//   o_empty      : no entry occupied
module func_skid_buf
  import func_drain_pkg::*;
(
  input  logic        aclk,
  input  logic        areset,
  input  logic        i_valid,
  input  drain_beat_t i_beat,
  output drain_beat_t o_beat,
  input  logic        i_ready,
  output logic        o_full,
  output logic        o_empty
);

  drain_beat_t r_head;
  drain_beat_t r_spare;
  logic        r_head_v;
  logic        r_spare_v;
  logic        w_push;
  logic        w_pop;

  // The spare is only ever filled while the head is occupied.
  assign o_full  = r_spare_v;
  assign o_empty = !r_head_v;
  assign o_beat  = r_head;
  assign w_push  = i_valid && !r_spare_v;
  assign w_pop   = r_head_v && i_ready;

  // NOTE: sequential state uses non-blocking assignments so every register
  // samples the pre-edge values regardless of statement order.
  always_ff @(posedge aclk) begin
    if (areset) begin
      r_head_v  <= 1'b0;
      r_spare_v <= 1'b0;
      // NOTE: the data registers are reset too because the output beat must
      // read as zero after reset; pure storage would normally be left alone.
      r_head    <= '0;
      r_spare   <= '0;
    end else if (w_pop) begin
      if (r_spare_v) begin
        // Full means no push this cycle; the spare moves up.
        r_head    <= r_spare;
        r_spare_v <= 1'b0;
      end else begin
        r_head_v <= w_push;
        if (w_push) r_head <= i_beat;
      end
    end else if (w_push) begin
      if (!r_head_v) begin
        r_head_v <= 1'b1;
        r_head   <= i_beat;
      end else begin
        r_spare_v <= 1'b1;
        r_spare   <= i_beat;
      end
    end
  end

endmodule

// File: rtl/func_stream_drain.sv
// Output stage behind func_hdl_top. After ctrl_start it forwards exactly
// N = ctrl_xfer_size_in_bytes >> BYTES_SHIFT beats to the AXI-stream write
// path, marks beat N with m_tlast, pulses ctrl_done once that beat has left,
// and drops every other input beat (stale data and pipeline flush tail).
// Ports:
//   aclk, areset            : clock, synchronous active-high reset
//   ctrl_start              : 1-cycle pulse, arms a transfer (ignored unless idle)
//   ctrl_xfer_size_in_bytes : transfer size, sampled on an accepted ctrl_start
//   ctrl_done               : 1-cycle pulse the cycle after beat N is accepted
//   s_tvalid/s_tdata/s_tready : input stream from func_hdl_top
//   m_tvalid/m_tdata/m_tlast/m_tready : output stream to the write path
//   stat_stall_cycles, stat_dropped_beats : statistics
// Build option: define TY_DRAIN_STATS_EN to generate the statistics counters;
// without it both statistics outputs read zero.
module func_stream_drain
  import func_drain_pkg::*;
#(
  parameter int C_DATA_WIDTH = DRAIN_DATA_W,
  parameter int BYTES_SHIFT  = 2,
  parameter int CNT_W        = 32
) (
  input  logic                    aclk,
  input  logic                    areset,
  input  logic                    ctrl_start,
  input  logic [31:0]             ctrl_xfer_size_in_bytes,
  output logic                    ctrl_done,
  input  logic                    s_tvalid,
  input  logic [C_DATA_WIDTH-1:0] s_tdata,
  output logic                    s_tready,
  output logic                    m_tvalid,
  output logic [C_DATA_WIDTH-1:0] m_tdata,
  output logic                    m_tlast,
  input  logic                    m_tready,
  output logic [31:0]             stat_stall_cycles,
  output logic [31:0]             stat_dropped_beats
);

  drain_state_t     r_state;
  drain_state_t     w_state_nxt;
  logic [CNT_W-1:0] r_n;
  logic [CNT_W-1:0] r_cnt;
  logic [CNT_W-1:0] w_n_new;
  logic             r_done;
  logic             w_done_nxt;
  logic             w_start_ok;
  logic             w_s_ready;
  logic             w_push;
  logic             w_last;
  logic             w_pop_last;
  logic             w_skid_full;
  logic             w_skid_empty;
  drain_beat_t      w_push_beat;
  drain_beat_t      w_m_beat;

  assign w_n_new = CNT_W'(ctrl_xfer_size_in_bytes >> BYTES_SHIFT);
  // Guarded so N_reg-1 never wraps when no transfer is armed.
  assign w_last  = (r_n != '0) && (r_cnt == r_n - CNT_W'(1));

  assign w_push_beat.data = s_tdata;
  assign w_push_beat.last = w_last;

  func_skid_buf u_skid (
    .aclk    (aclk),
    .areset  (areset),
    .i_valid (w_push),
    .i_beat  (w_push_beat),
    .o_beat  (w_m_beat),
    .i_ready (m_tready),
    .o_full  (w_skid_full),
    .o_empty (w_skid_empty)
  );

  assign m_tvalid   = !w_skid_empty;
  assign m_tdata    = w_m_beat.data;
  assign m_tlast    = w_m_beat.last;
  assign w_pop_last = m_tvalid && m_tready && m_tlast;
  // Held low during reset so upstream sees no handshake while aborting.
  assign s_tready   = w_s_ready && !areset;
  assign ctrl_done  = r_done;

  always_ff @(posedge aclk) begin
    if (areset) r_state <= ST_IDLE;
    else        r_state <= w_state_nxt;
  end

  always_comb begin
    // NOTE: every combinational output gets a default first so no path
    // through the case statement can infer a latch.
    w_state_nxt = r_state;
    w_s_ready   = 1'b0;
    w_push      = 1'b0;
    w_start_ok  = 1'b0;
    w_done_nxt  = 1'b0;
    case (r_state)
      ST_IDLE: begin
        // Input drains freely; the beat coincident with the start is dropped.
        w_s_ready = 1'b1;
        if (ctrl_start) begin
          w_start_ok = 1'b1;
          if (w_n_new == '0) w_done_nxt  = 1'b1;
          else               w_state_nxt = ST_RUN;
        end
      end
      ST_RUN: begin
        w_s_ready = !w_skid_full;
        w_push    = s_tvalid && !w_skid_full;
        if (w_push && w_last) w_state_nxt = ST_TAIL;
      end
      ST_TAIL: begin
        // Flush-tail beats are swallowed while the last beats drain out.
        w_s_ready = 1'b1;
        if (w_pop_last) begin
          w_done_nxt  = 1'b1;
          w_state_nxt = ST_IDLE;
        end
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_n    <= '0;
      r_cnt  <= '0;
      r_done <= 1'b0;
    end else begin
      r_done <= w_done_nxt;
      if (w_start_ok) begin
        r_n   <= w_n_new;
        r_cnt <= '0;
      end else if (w_push) begin
        r_cnt <= r_cnt + CNT_W'(1);
      end
    end
  end

`ifdef TY_DRAIN_STATS_EN
  logic [31:0] r_stall_cnt;
  logic [31:0] r_drop_cnt;
  logic        w_drop;

  assign w_drop = s_tvalid && s_tready && (r_state != ST_RUN);

  always_ff @(posedge aclk) begin
    if (areset) begin
      r_stall_cnt <= '0;
      r_drop_cnt  <= '0;
    end else if (w_start_ok) begin
      r_stall_cnt <= '0;
      r_drop_cnt  <= '0;
    end else begin
      if (m_tvalid && !m_tready) r_stall_cnt <= sat_inc(r_stall_cnt);
      if (w_drop)                r_drop_cnt  <= sat_inc(r_drop_cnt);
    end
  end

  assign stat_stall_cycles  = r_stall_cnt;
  assign stat_dropped_beats = r_drop_cnt;
`else
  assign stat_stall_cycles  = '0;
  assign stat_dropped_beats = '0;
`endif

endmodule
